ofmap_sram_ctrl: RTL and testbench

- Controller in front of the single-port output-feature-map SRAM (BRAM_OFmaps, 64-bit word, 13-bit address).
- Shares the one port between two users: PE result writeback (write stream) and an output drain engine (sequential read).
- The drain engine streams a programmed address range out over a valid/ready interface toward the DMA/FIFO path.
- Hides SRAM read latency with a credit-controlled output FIFO.

---
 rtl/ofmap_sram_ctrl_if.sv | 49 ++++
 rtl/ofmap_sram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ofmap_sram_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_sram_ctrl_if.sv
// Bundle of the OFmap SRAM controller's handshakes and SRAM port.
// The master modport is the controller's view; slave is the environment's view.
interface ofmap_sram_ctrl_if #(
  parameter int NOD    = 8,
  parameter int DBITS  = 8,
  parameter int OABITS = 13
) ();
  localparam int W = NOD * DBITS;

  logic              wr_valid;
  logic              wr_ready;
  logic [OABITS-1:0] wr_addr;
  logic [W-1:0]      wr_data;

  logic              drain_start;
  logic [OABITS-1:0] drain_base;
  logic [OABITS:0]   drain_len;
  logic              drain_busy;
  logic              drain_done;

  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_data;
  logic              m_last;

  logic              en_ofmap;
  logic              wea_ofmap;
  logic [OABITS-1:0] addr_ofmap;
  logic [W-1:0]      din_ofmap;
  logic [W-1:0]      dout_ofmap;

  modport master (
    input  wr_valid, wr_addr, wr_data,
    input  drain_start, drain_base, drain_len,
    input  m_ready, dout_ofmap,
    output wr_ready, drain_busy, drain_done,
    output m_valid, m_data, m_last,
    output en_ofmap, wea_ofmap, addr_ofmap, din_ofmap
  );

  modport slave (
    output wr_valid, wr_addr, wr_data,
    output drain_start, drain_base, drain_len,
    output m_ready, dout_ofmap,
    input  wr_ready, drain_busy, drain_done,
    input  m_valid, m_data, m_last,
    input  en_ofmap, wea_ofmap, addr_ofmap, din_ofmap
  );
endinterface

// File: rtl/ofmap_sram_ctrl.sv
// Single-port OFmap SRAM arbiter: PE writeback vs. a sequential drain engine
// that streams a range out through a credit-controlled output FIFO.
module ofmap_sram_ctrl #(
  parameter int NOD         = 8,
  parameter int DBITS       = 8,
  parameter int OABITS      = 13,
  parameter int RDLAT       = 1,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  ofmap_sram_ctrl_if.master bus
);
  localparam int W  = NOD * DBITS;
  localparam int CW = $clog2(OFIFO_DEPTH + 1);
  localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam logic [CW:0]     CREDITS   = (CW+1)'(OFIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_SLOT = PW'(OFIFO_DEPTH - 1);
  localparam logic [OABITS:0] LEFT_ONE  = (OABITS+1)'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [OABITS-1:0] rd_addr;
  logic [OABITS:0]   rd_left;
  logic              rr_rd_last;
  logic [RDLAT-1:0]  pipe_v;
  logic [RDLAT-1:0]  pipe_last;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [W:0]        fifo_mem [OFIFO_DEPTH];

  logic rd_elig;
  logic rd_issue;
  logic wr_fire;
  logic pipe_exit;
  logic fifo_nonempty;
  logic fifo_pop;
  logic drain_load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // A read needs a guaranteed FIFO slot: in-flight reads plus stored words stay below depth.
  assign rd_elig = (state == DRAIN) && (rd_left != '0) &&
                   (({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS);

  // On a contested cycle the side that lost last time wins, so neither waits twice.
  assign wr_fire  = bus.wr_valid && (!rd_elig || rr_rd_last);
  assign rd_issue = rd_elig && (!bus.wr_valid || !rr_rd_last);

  assign pipe_exit     = pipe_v[RDLAT-1];
  assign fifo_nonempty = (fifo_count != '0);
  assign fifo_pop      = fifo_nonempty && bus.m_ready;
  assign drain_load    = (state == IDLE) && bus.drain_start && (bus.drain_len != '0);

  assign bus.wr_ready   = wr_fire;
  assign bus.en_ofmap   = wr_fire | rd_issue;
  assign bus.wea_ofmap  = wr_fire;
  assign bus.addr_ofmap = wr_fire ? bus.wr_addr : rd_addr;
  assign bus.din_ofmap  = wr_fire ? bus.wr_data : '0;

  assign bus.drain_busy = (state == DRAIN) || (state == FLUSH);
  assign bus.drain_done = (state == DONE);

  assign bus.m_valid = fifo_nonempty;
  assign bus.m_data  = fifo_nonempty ? fifo_mem[rd_ptr][W-1:0] : '0;
  assign bus.m_last  = fifo_nonempty && fifo_mem[rd_ptr][W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.drain_start) begin
          state_nxt = (bus.drain_len == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (rd_issue && (rd_left == LEFT_ONE)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if ((inflight == '0) && (fifo_count == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr <= '0;
      rd_left <= '0;
    end else if (drain_load) begin
      rd_addr <= bus.drain_base;
      rd_left <= bus.drain_len;
    end else if (rd_issue) begin
      rd_addr <= rd_addr + 1'b1;
      rd_left <= rd_left - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_rd_last <= 1'b0;
    end else if (bus.wr_valid && rd_elig) begin
      rr_rd_last <= rd_issue;
    end
  end

  // Issue tags ride alongside the SRAM latency so dout is captured on the exact cycle it is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v    <= '0;
      pipe_last <= '0;
      inflight  <= '0;
    end else begin
      pipe_v[0]    <= rd_issue;
      pipe_last[0] <= rd_issue && (rd_left == LEFT_ONE);
      for (int i = 1; i < RDLAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      inflight <= inflight + CW'(rd_issue) - CW'(pipe_exit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (pipe_exit) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_count <= fifo_count + CW'(pipe_exit) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_exit) begin
      fifo_mem[wr_ptr] <= {pipe_last[RDLAT-1], bus.dout_ofmap};
    end
  end
endmodule

// File: tb/tb_ofmap_sram_ctrl.sv
// Directed bench for ofmap_sram_ctrl with an SRAM model, a beat scoreboard and
// a read-address scoreboard; all expectations come from the bench's shadow memory.
module tb_ofmap_sram_ctrl;
  localparam int NOD = 8, DBITS = 8, OABITS = 13, RDLAT = 1, OFIFO_DEPTH = 4;
  localparam int W = NOD * DBITS;
  localparam int NWORDS = 1 << OABITS;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  ofmap_sram_ctrl_if #(.NOD(NOD), .DBITS(DBITS), .OABITS(OABITS)) bus ();

  ofmap_sram_ctrl #(
    .NOD(NOD), .DBITS(DBITS), .OABITS(OABITS), .RDLAT(RDLAT), .OFIFO_DEPTH(OFIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sram   [NWORDS];
  logic [W-1:0] shadow [NWORDS];

  beat_t             exp_q [$];
  logic [OABITS-1:0] rdq   [$];

  int n_cmp = 0;
  int n_err = 0;
  int beats_seen = 0;
  int done_count = 0;
  int outstanding = 0;
  int drain_beats0 = 0;
  int drain_len_cur = 0;
  int wj = 0;
  int b0 = 0;
  int done_before = 0;

  logic         hold_prev = 1'b0;
  logic         prev_done = 1'b0;
  logic         prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         rd_fire;
  logic         pop;
  beat_t        mon_beat;
  logic [OABITS-1:0] mon_addr;

  function automatic logic [W-1:0] init_word(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'(a) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a drain-start request and record the beats and read addresses it must produce.
  task automatic applyStimulus(input int base, input int len);
    int a;
    drain_beats0  = beats_seen;
    drain_len_cur = len;
    for (int k = 0; k < len; k++) begin
      a = (base + k) % NWORDS;
      exp_q.push_back({shadow[a], (k == len - 1)});
      rdq.push_back(OABITS'(a));
    end
    bus.drain_start = 1'b1;
    bus.drain_base  = OABITS'(base);
    bus.drain_len   = (OABITS+1)'(len);
  endtask

  task automatic waitDone(input int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (bus.drain_done) begin
        got = 1'b1;
        checkOutput("busy_low_at_done", 64'(bus.drain_busy), 64'd0);
      end
    end
    checkOutput("drain_done_seen", 64'(got), 64'd1);
    checkOutput("beats_outstanding", 64'(exp_q.size()), 64'd0);
    checkOutput("beat_count", 64'(beats_seen - drain_beats0), 64'(drain_len_cur));
    @(posedge clk);
    #1;
  endtask

  // SRAM model: one port, registered read data one cycle after enable.
  always @(posedge clk) begin
    if (bus.en_ofmap) begin
      if (bus.wea_ofmap) begin
        sram[bus.addr_ofmap] = bus.din_ofmap;
      end else begin
        bus.dout_ofmap <= sram[bus.addr_ofmap];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      rdq.delete();
      outstanding = 0;
      hold_prev   = 1'b0;
      prev_done   = 1'b0;
    end else begin
      rd_fire = bus.en_ofmap && !bus.wea_ofmap;
      pop     = bus.m_valid && bus.m_ready;
      if (rd_fire) begin
        checkOutput("read_expected", 64'(rdq.size() != 0), 64'd1);
        if (rdq.size() != 0) begin
          mon_addr = rdq.pop_front();
          checkOutput("read_addr", 64'(bus.addr_ofmap), 64'(mon_addr));
        end
        checkOutput("credit_limit", 64'(outstanding + 1 <= OFIFO_DEPTH), 64'd1);
      end
      if (hold_prev) begin
        checkOutput("hold_valid", 64'(bus.m_valid), 64'd1);
        checkOutput("hold_data", bus.m_data, prev_data);
        checkOutput("hold_last", 64'(bus.m_last), 64'(prev_last));
      end
      if (pop) begin
        checkOutput("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_beat = exp_q.pop_front();
          checkOutput("beat_data", bus.m_data, mon_beat.data);
          checkOutput("beat_last", 64'(bus.m_last), 64'(mon_beat.last));
        end
        beats_seen++;
      end
      if (bus.drain_done) begin
        checkOutput("done_single_cycle", 64'(prev_done), 64'd0);
        done_count++;
      end
      outstanding = outstanding + int'(rd_fire) - int'(pop);
      hold_prev   = bus.m_valid && !bus.m_ready;
      prev_data   = bus.m_data;
      prev_last   = bus.m_last;
      prev_done   = bus.drain_done;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 50000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      sram[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
    reset           = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.drain_start = 1'b0;
    bus.drain_base  = '0;
    bus.drain_len   = '0;
    bus.m_ready     = 1'b1;

    #2;
    checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("rst_drain_busy", 64'(bus.drain_busy), 64'd0);
    checkOutput("rst_drain_done", 64'(bus.drain_done), 64'd0);
    checkOutput("rst_m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("rst_m_last", 64'(bus.m_last), 64'd0);
    checkOutput("rst_m_data", bus.m_data, 64'd0);
    checkOutput("rst_en", 64'(bus.en_ofmap), 64'd0);
    checkOutput("rst_wea", 64'(bus.wea_ofmap), 64'd0);
    checkOutput("rst_addr", 64'(bus.addr_ofmap), 64'd0);
    checkOutput("rst_din", bus.din_ofmap, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    $display("[TB] reset released");

    // Write-only burst while idle: every cycle granted.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'(17 * (i + 1));
      bus.wr_valid = 1'b1;
      bus.wr_addr  = OABITS'(i);
      bus.wr_data  = {8{b}};
      shadow[i]    = {8{b}};
      @(negedge clk);
      checkOutput("wr_ready_idle", 64'(bus.wr_ready), 64'd1);
      checkOutput("wr_en", 64'(bus.en_ofmap), 64'd1);
      checkOutput("wr_wea", 64'(bus.wea_ofmap), 64'd1);
      checkOutput("wr_addr", 64'(bus.addr_ofmap), 64'(i));
      checkOutput("wr_din", bus.din_ofmap, {8{b}});
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_en_low", 64'(bus.en_ofmap), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] drain base=0 len=4");
    applyStimulus(0, 4);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", 64'(bus.drain_busy), 64'd1);
    waitDone(40);

    $display("[TB] backpressure base=0 len=8");
    applyStimulus(0, 8);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    waitDone(60);

    $display("[TB] contention base=0 len=4 with writes held");
    wj = 0;
    for (int k = 0; k < 9; k++) begin
      logic exp_grant;
      exp_grant    = (k % 2 == 0);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = OABITS'(100 + wj);
      bus.wr_data  = 64'hDEAD_BEEF_0000_0000 | 64'(wj);
      if (k == 0) applyStimulus(0, 4);
      @(negedge clk);
      checkOutput($sformatf("cont_wr_ready_%0d", k), 64'(bus.wr_ready), 64'(exp_grant));
      checkOutput("cont_en", 64'(bus.en_ofmap), 64'd1);
      if (exp_grant) begin
        checkOutput("cont_wr_addr", 64'(bus.addr_ofmap), 64'(100 + wj));
      end
      @(posedge clk);
      #1;
      bus.drain_start = 1'b0;
      if (exp_grant) begin
        shadow[100 + wj] = bus.wr_data;
        wj++;
      end
    end
    bus.wr_valid = 1'b0;
    waitDone(40);

    $display("[TB] drain back the contended writes base=100 len=5");
    applyStimulus(100, 5);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    waitDone(40);

    $display("[TB] wrap base=8190 len=4");
    applyStimulus(8190, 4);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    waitDone(40);

    $display("[TB] zero-length drain");
    b0 = beats_seen;
    applyStimulus(5, 0);
    @(negedge clk);
    checkOutput("zero_done_start_cycle", 64'(bus.drain_done), 64'd0);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    @(negedge clk);
    checkOutput("zero_done_pulse", 64'(bus.drain_done), 64'd1);
    checkOutput("zero_busy", 64'(bus.drain_busy), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("zero_done_cleared", 64'(bus.drain_done), 64'd0);
    checkOutput("zero_no_beats", 64'(beats_seen - b0), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-drain base=0 len=8");
    applyStimulus(0, 8);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    b0 = drain_beats0;
    for (int i = 0; i < 50 && beats_seen < b0 + 2; i++) @(negedge clk);
    checkOutput("rst_mid_two_beats", 64'(beats_seen - b0 >= 2), 64'd1);
    @(posedge clk);
    #2;
    done_before = done_count;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.drain_busy), 64'd0);
    checkOutput("mid_rst_done", 64'(bus.drain_done), 64'd0);
    checkOutput("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("mid_rst_m_last", 64'(bus.m_last), 64'd0);
    checkOutput("mid_rst_m_data", bus.m_data, 64'd0);
    checkOutput("mid_rst_en", 64'(bus.en_ofmap), 64'd0);
    checkOutput("mid_rst_wea", 64'(bus.wea_ofmap), 64'd0);
    checkOutput("mid_rst_addr", 64'(bus.addr_ofmap), 64'd0);
    checkOutput("mid_rst_din", bus.din_ofmap, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no_done_after_rst", 64'(done_count - done_before), 64'd0);
    checkOutput("no_valid_after_rst", 64'(bus.m_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 2);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    waitDone(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
